gemm_result_drain: RTL and testbench
====================================

# gemm_result_drain

Downstream stage of the GEMM controller and systolic array. Captures each result row on the controller's `we_c` strobe and requantizes every accumulator to OUT_W bits with round-half-up and saturation. Buffers rows in a small FIFO and serializes them as one element per beat on a valid/ready stream toward the output writer. Also flags job completion, and reports overflow when rows arrive while the FIFO is full.

## Interface
- N, 4, array width; elements per result row
- K, 4, result rows per job; row index K-1 ends a job
- ACC_W, 32, signed accumulator width per element
- OUT_W, 8, signed output element width
- ADDR_WIDTH, 8, row index width; matches controller `addr_c`
- FIFO_DEPTH, 4, row FIFO depth; power of two, ≥2
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  job start pulse, same pulse the controller receives
- shift  in  5  right-shift amount; latched on `start`
- we_c  in  1  row capture strobe from controller
- addr_c  in  ADDR_WIDTH  row index accompanying `we_c`
- c_row  in  N*ACC_W  accumulator row; element j at [j*ACC_W +: ACC_W]
- out_valid  out  1  output element valid
- out_ready  in  1  downstream accepts element
- out_data  out  OUT_W  requantized element, signed
- out_row  out  ADDR_WIDTH  row index of current element
- out_col  out  max(1,$clog2(N))  column index of current element
- out_last  out  1  final element of row K-1
- job_done  out  1  one-cycle pulse after the `out_last` handshake
- overflow  out  1  sticky; a row was dropped
- fifo_level  out  $clog2(FIFO_DEPTH)+1  rows held

## Operation
- Reset values: all outputs 0. FIFO empty, col index 0, latched shift 0.
- `start`: latch `shift`, clear `overflow`, flush the FIFO, reset col index to 0. If `start` and `we_c` occur in the same cycle, `start` wins and the row is dropped without setting `overflow`.
- Push: on `we_c`, each element is quantized and written with `addr_c` into the FIFO. Quantization happens at push time, so the FIFO stores OUT_W*N data bits plus ADDR_WIDTH.
- Quantization, in ACC_W+1 bit signed arithmetic:
  - r = acc + (shift>0 ? 1<<(shift-1) : 0)
  - q = r >>> shift
  - saturate q to [-2^(OUT_W-1), 2^(OUT_W-1)-1]
- Pop/serialize:
  - `out_valid` = FIFO not empty. `out_data` is element `out_col` of the head row. `out_row` is the head row's index.
  - On `out_valid & out_ready`, col increments. When col = N-1, col wraps to 0 and the head row is popped.
- `out_last` = `out_valid` & col = N-1 & `out_row` = K-1.
- `job_done` pulses on the cycle after the handshake that had `out_last` set.
- Full behaviour: a push is accepted if level < FIFO_DEPTH, or if a pop occurs in the same cycle. Otherwise the row is dropped and `overflow` is set. The controller cannot be stalled.
- Simultaneous push and pop: level is unchanged and the write pointer still advances.
- `out_valid` never deasserts while not accepted, except on `start` (flush) or reset.
- Reset mid-operation: everything returns to reset values immediately. Partial rows are discarded.

## Timing
- Push latency: a `we_c` sampled at edge t makes the row visible at the FIFO head at t+1, provided the FIFO was empty.
- Output path: `out_data`, `out_row`, `out_col` and `out_last` are combinational from registers only. There is no path from `out_ready` to `out_valid`.
- Throughput: one element per cycle with `out_ready` held high, i.e. one row per N cycles. With N=4 and K=4, the controller's back-to-back `we_c` bursts outrun the drain, so FIFO_DEPTH ≥ K-K/N+1 is required for lossless operation at full rate.
- `fifo_level` updates on the edge after a push or pop.
- `overflow` is set on the edge after the dropped `we_c`.

## Configuration
- `GEMM_DRAIN_RELU_EN` defined: after rounding and shifting, negative q is forced to 0 before saturation. The output range becomes [0, 2^(OUT_W-1)-1].
- Undefined: signed output as specified above. No ReLU logic is present.

## Test plan
- Reset, then `start` with shift=4. Push row 0 as {296, -40, 0, 7} with addr_c=0, `out_ready`=1 -> `out_data` is 19, -2, 0, 0 on four consecutive cycles, `out_col` runs 0..3, `out_last`=0.
- Shift=0, push {5000, -5000, 127, -128} -> outputs 127, -128, 127, -128 (saturation); with `GEMM_DRAIN_RELU_EN` -> 127, 0, 127, 0.
- Shift=3, acc=-40 -> -5; acc=-36 -> -4 (round-half-up boundary).
- K=4 rows pushed on consecutive cycles, `out_ready`=0 for 10 cycles, then 1 -> `fifo_level`=4, no `overflow`, 16 elements delivered in order, `out_last` only on row 3 col 3, `job_done` one cycle later.
- Fill FIFO with `out_ready`=0, push a fifth row -> `overflow`=1, that row is absent from the output. Next `start` clears `overflow` and `fifo_level` becomes 0.
- Assert rst_n=0 mid-row (col=2) -> `out_valid`=0, `fifo_level`=0 immediately. Push after release -> the first element out has `out_col`=0.

Source files
------------

// File: rtl/gemm_result_drain.sv
// Result drain for the GEMM array: requantizes captured rows, buffers them in a row FIFO
// and serializes one element per beat. Define GEMM_DRAIN_RELU_EN to clamp negatives to zero.
module gemm_result_drain #(
    parameter int N          = 4,
    parameter int K          = 4,
    parameter int ACC_W      = 32,
    parameter int OUT_W      = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    input  logic [4:0]                          shift,
    input  logic                                we_c,
    input  logic [ADDR_WIDTH-1:0]               addr_c,
    input  logic [N*ACC_W-1:0]                  c_row,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [OUT_W-1:0]                    out_data,
    output logic [ADDR_WIDTH-1:0]               out_row,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] out_col,
    output logic                                out_last,
    output logic                                job_done,
    output logic                                overflow,
    output logic [$clog2(FIFO_DEPTH):0]         fifo_level
);

    localparam int COL_W = (N > 1) ? $clog2(N) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int ROW_W = N * OUT_W + ADDR_WIDTH;

    // Round-half-up, arithmetic shift and saturate in ACC_W+1 bits so the rounding add cannot wrap.
    function automatic logic [OUT_W-1:0] quantize(input logic [ACC_W-1:0] acc, input logic [4:0] sh);
        logic signed [ACC_W:0] rnd;
        logic signed [ACC_W:0] r;
        logic signed [ACC_W:0] q;
        logic signed [ACC_W:0] max_v;
        logic signed [ACC_W:0] min_v;
        logic [OUT_W-1:0]      res;
        max_v = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
        min_v = ~max_v;
        if (sh != 5'd0) begin
            rnd = {{ACC_W{1'b0}}, 1'b1} << (sh - 5'd1);
        end else begin
            rnd = '0;
        end
        r = $signed({acc[ACC_W-1], acc}) + rnd;
        q = r >>> sh;
`ifdef GEMM_DRAIN_RELU_EN
        if (q[ACC_W]) begin
            q = '0;
        end else begin
            q = q;
        end
`endif
        if (q > max_v) begin
            res = max_v[OUT_W-1:0];
        end else if (q < min_v) begin
            res = min_v[OUT_W-1:0];
        end else begin
            res = q[OUT_W-1:0];
        end
        return res;
    endfunction

    logic [4:0]            shift_r;
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [LVL_W-1:0]      level_r;
    logic [COL_W-1:0]      col_r;
    logic                  overflow_r;
    logic                  job_done_r;
    logic [ROW_W-1:0]      mem_r [FIFO_DEPTH];
    logic [ROW_W-1:0]      push_row_s;
    logic [ROW_W-1:0]      head_s;
    logic                  valid_s;
    logic                  hs_s;
    logic                  col_end_s;
    logic                  pop_s;
    logic                  push_req_s;
    logic                  push_ok_s;
    logic                  last_s;

    assign valid_s    = (level_r != {LVL_W{1'b0}});
    assign hs_s       = valid_s & out_ready;
    assign col_end_s  = (col_r == COL_W'(N - 1));
    assign pop_s      = hs_s & col_end_s;
    assign push_req_s = we_c & ~start;
    assign push_ok_s  = push_req_s & ((level_r < LVL_W'(FIFO_DEPTH)) | pop_s);
    assign head_s     = mem_r[rd_ptr_r];
    assign last_s     = valid_s & col_end_s & (head_s[N*OUT_W +: ADDR_WIDTH] == ADDR_WIDTH'(K - 1));

    // Quantize the incoming row and append its index above the element fields.
    always_comb begin
        push_row_s = '0;
        for (int j = 0; j < N; j++) begin
            push_row_s[j*OUT_W +: OUT_W] = quantize(c_row[j*ACC_W +: ACC_W], shift_r);
        end
        push_row_s[N*OUT_W +: ADDR_WIDTH] = addr_c;
    end

    // Row storage; contents are don't-care while the level says empty.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_row_s;
        end
    end

    // FIFO pointers, level, column counter, latched shift and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r    <= 5'd0;
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            level_r    <= '0;
            col_r      <= '0;
            overflow_r <= 1'b0;
        end else if (start) begin
            shift_r    <= shift;
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            level_r    <= '0;
            col_r      <= '0;
            overflow_r <= 1'b0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (hs_s) begin
                if (col_end_s) begin
                    col_r    <= '0;
                    rd_ptr_r <= rd_ptr_r + PTR_W'(1);
                end else begin
                    col_r <= col_r + COL_W'(1);
                end
            end
            level_r    <= level_r + LVL_W'(push_ok_s) - LVL_W'(pop_s);
            overflow_r <= overflow_r | (push_req_s & ~push_ok_s);
        end
    end

    // Completion pulse one cycle after the final element of the last row is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            job_done_r <= 1'b0;
        end else begin
            job_done_r <= hs_s & last_s;
        end
    end

    // Element select from the head row; forced to zero while empty so outputs idle at 0.
    always_comb begin
        if (valid_s) begin
            out_data = head_s[col_r*OUT_W +: OUT_W];
            out_row  = head_s[N*OUT_W +: ADDR_WIDTH];
        end else begin
            out_data = '0;
            out_row  = '0;
        end
    end

    assign out_valid  = valid_s;
    assign out_col    = col_r;
    assign out_last   = last_s;
    assign job_done   = job_done_r;
    assign overflow   = overflow_r;
    assign fifo_level = level_r;

endmodule

// File: tb/tb_gemm_result_drain.sv
// Directed bench for gemm_result_drain: row-queue reference model checked every cycle,
// plus hand-computed literal expectations from the quantization and flow-control rules.
module tb_gemm_result_drain;

    localparam int N     = 4;
    localparam int K     = 4;
    localparam int ACC_W = 32;
    localparam int OUT_W = 8;
    localparam int AW    = 8;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [4:0]        shift;
    logic              we_c;
    logic [AW-1:0]     addr_c;
    logic [N*ACC_W-1:0] c_row;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic [AW-1:0]     out_row;
    logic [1:0]        out_col;
    logic              out_last;
    logic              job_done;
    logic              overflow;
    logic [2:0]        fifo_level;

    gemm_result_drain #(.N(N), .K(K), .ACC_W(ACC_W), .OUT_W(OUT_W), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .shift(shift), .we_c(we_c), .addr_c(addr_c),
        .c_row(c_row), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_row(out_row), .out_col(out_col), .out_last(out_last), .job_done(job_done),
        .overflow(overflow), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    typedef struct { int addr; int d[N]; } row_t;
    typedef struct { int d; int r; int c; bit l; } el_t;

    int   vectors = 0;
    int   miscompares = 0;
    int   acc_v[N];
    row_t rq[$];
    el_t  log_q[$];
    int   mcol = 0;
    bit   movf = 1'b0;
    bit   mjob = 1'b0;
    int   msh = 0;
    int   jd_count = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference quantizer using floor division rather than shifts.
    function automatic int quant(input longint acc, input int sh);
        longint r, d, q;
        r = acc + ((sh > 0) ? (longint'(1) << (sh - 1)) : longint'(0));
        d = longint'(1) << sh;
        q = r / d;
        if (r < 0 && (r % d) != 0) q = q - 1;
`ifdef GEMM_DRAIN_RELU_EN
        if (q < 0) q = 0;
`endif
        if (q > 127) q = 127;
        if (q < -128) q = -128;
        return int'(q);
    endfunction

    task automatic model_reset();
        rq.delete();
        mcol = 0;
        movf = 1'b0;
        mjob = 1'b0;
        msh  = 0;
    endtask

    task automatic set_row(input int a0, input int a1, input int a2, input int a3);
        acc_v[0] = a0; acc_v[1] = a1; acc_v[2] = a2; acc_v[3] = a3;
        for (int j = 0; j < N; j++) c_row[j*ACC_W +: ACC_W] = acc_v[j];
    endtask

    task automatic compare();
        chk("out_valid", out_valid, (rq.size() > 0) ? 1 : 0);
        chk("fifo_level", fifo_level, rq.size());
        chk("overflow", overflow, movf);
        chk("job_done", job_done, mjob);
        if (rq.size() > 0) begin
            chk("out_data", int'($signed(out_data)), rq[0].d[mcol]);
            chk("out_row", out_row, rq[0].addr);
            chk("out_col", out_col, mcol);
            chk("out_last", out_last, (mcol == N-1 && rq[0].addr == K-1) ? 1 : 0);
        end
    endtask

    // One clock: log the handshake, advance, update the model from the sampled inputs, compare.
    task automatic cycle();
        bit st, we, rdy, rs;
        int ad, sh, pre_col;
        bit hs, pop, last_hs;
        row_t nr;
        if (out_valid && out_ready)
            log_q.push_back('{d: int'($signed(out_data)), r: int'(out_row), c: int'(out_col), l: out_last});
        st = start; we = we_c; rdy = out_ready; rs = rst_n; ad = int'(addr_c); sh = int'(shift);
        @(posedge clk);
        #1;
        if (!rs) begin
            model_reset();
        end else begin
            hs      = (rq.size() > 0) && rdy;
            pre_col = mcol;
            last_hs = hs && pre_col == N-1 && rq[0].addr == K-1;
            pop     = hs && pre_col == N-1;
            if (st) begin
                rq.delete();
                mcol = 0;
                movf = 1'b0;
                msh  = sh;
            end else begin
                nr.addr = ad;
                for (int j = 0; j < N; j++) nr.d[j] = quant(longint'(acc_v[j]), msh);
                if (hs) begin
                    if (pop) begin
                        void'(rq.pop_front());
                        mcol = 0;
                    end else begin
                        mcol = mcol + 1;
                    end
                end
                if (we) begin
                    if (rq.size() < DEPTH || pop) rq.push_back(nr);
                    else movf = 1'b1;
                end
            end
            mjob = last_hs;
        end
        compare();
        if (job_done) jd_count++;
        start = 1'b0;
        we_c  = 1'b0;
    endtask

    task automatic push(input int ad, input int a0, input int a1, input int a2, input int a3);
        set_row(a0, a1, a2, a3);
        addr_c = AW'(ad);
        we_c = 1'b1;
        cycle();
    endtask

    task automatic do_start(input int sh);
        shift = 5'(sh);
        start = 1'b1;
        cycle();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic expect_row(input string tag, input int e0, input int e1, input int e2, input int e3);
        int e[N];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        chk({tag, "_count"}, log_q.size(), N);
        if (log_q.size() >= N) begin
            for (int i = 0; i < N; i++) begin
                chk({tag, "_data"}, log_q[i].d, e[i]);
                chk({tag, "_col"}, log_q[i].c, i);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; shift = 5'd0; we_c = 1'b0; addr_c = '0; out_ready = 1'b0;
        set_row(0, 0, 0, 0);
        model_reset();

        // Model pins against hand-computed values.
        chk("model_q_296_s4", quant(296, 4), 19);
        chk("model_q_m40_s3", quant(-40, 3), 0 + `ifdef GEMM_DRAIN_RELU_EN 0 `else -5 `endif);
        chk("model_q_m36_s3", quant(-36, 3), 0 + `ifdef GEMM_DRAIN_RELU_EN 0 `else -4 `endif);

        run(2);
        chk("rst_valid", out_valid, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_col", out_col, 0);
        chk("rst_data", out_data, 0);
        rst_n = 1'b1;
        run(1);

        // Rounding with shift 4.
        do_start(4);
        out_ready = 1'b1;
        log_q.delete();
        push(0, 296, -40, 0, 7);
        chk("push_latency_valid", out_valid, 1);
        run(6);
`ifdef GEMM_DRAIN_RELU_EN
        expect_row("t1", 19, 0, 0, 0);
`else
        expect_row("t1", 19, -2, 0, 0);
`endif
        foreach (log_q[i]) chk("t1_last", log_q[i].l, 0);

        // Saturation with shift 0.
        do_start(0);
        log_q.delete();
        push(1, 5000, -5000, 127, -128);
        run(6);
`ifdef GEMM_DRAIN_RELU_EN
        expect_row("t2", 127, 0, 127, 0);
`else
        expect_row("t2", 127, -128, 127, -128);
`endif

        // Round-half-up boundary with shift 3.
        do_start(3);
        log_q.delete();
        push(2, -40, -36, 20, 12);
        run(6);
`ifdef GEMM_DRAIN_RELU_EN
        expect_row("t3", 0, 0, 3, 2);
`else
        expect_row("t3", -5, -4, 3, 2);
`endif

        // Full job buffered with the stream stalled, then drained.
        out_ready = 1'b0;
        do_start(2);
        for (int i = 0; i < K; i++) push(i, 40*i, 40*i + 4, 40*i + 8, 40*i + 12);
        run(10);
        chk("t4_level", fifo_level, 4);
        chk("t4_ovf", overflow, 0);
        log_q.delete();
        jd_count = 0;
        out_ready = 1'b1;
        run(20);
        chk("t4_count", log_q.size(), N*K);
        if (log_q.size() >= N*K) begin
            for (int i = 0; i < N*K; i++) begin
                chk("t4_data", log_q[i].d, 10*(i/N) + (i%N));
                chk("t4_row", log_q[i].r, i/N);
                chk("t4_last", log_q[i].l, (i == N*K-1) ? 1 : 0);
            end
        end
        chk("t4_job_done_pulses", jd_count, 1);

        // Overflow: fifth row dropped while full.
        out_ready = 1'b0;
        do_start(0);
        for (int i = 0; i < 5; i++) push(i, 10*i, 10*i + 1, 10*i + 2, 10*i + 3);
        chk("t5_ovf_set", overflow, 1);
        chk("t5_level", fifo_level, 4);
        log_q.delete();
        out_ready = 1'b1;
        run(20);
        chk("t5_count", log_q.size(), N*K);
        foreach (log_q[i]) chk("t5_no_row4", (log_q[i].r == 4) ? 1 : 0, 0);
        chk("t5_ovf_sticky", overflow, 1);
        do_start(0);
        chk("t5_ovf_clr", overflow, 0);
        chk("t5_level_clr", fifo_level, 0);

        // Asynchronous reset in the middle of a row.
        push(0, 1, 2, 3, 4);
        run(2);
        chk("t6_col_before", out_col, 2);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_level", fifo_level, 0);
        chk("t6_rst_col", out_col, 0);
        model_reset();
        run(1);
        rst_n = 1'b1;
        log_q.delete();
        push(1, 9, 8, 7, 6);
        chk("t6_first_col", out_col, 0);
        chk("t6_first_data", int'($signed(out_data)), 9);
        run(6);
        expect_row("t6", 9, 8, 7, 6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
